// File: rtl/serial_frame_loader.sv
// rtl/serial_frame_loader.sv - framed MSB-first serial parser feeding the key/message deserializers
module serial_frame_loader #(
    parameter int         KEY_SIZE = 32,
    parameter int         MSG_SIZE = 512,
    parameter logic [7:0] SYNC     = 8'hA5,
    parameter int         TIMEOUT  = 1024
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEn,
    input  logic       iSerial_in,
    output logic       oData,
    output logic       oBit_en,
    output logic       oLoad_key,
    output logic       oLoad_msg,
    output logic       oBusy,
    output logic       oFrame_ok,
    output logic       oFrame_err,
    output logic [1:0] oErr_code
);
    localparam int CW = $clog2(MSG_SIZE) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] KEY_LAST = CW'(KEY_SIZE - 1);
    localparam logic [CW-1:0] MSG_LAST = CW'(MSG_SIZE - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {HUNT, TYPE, PAYLOAD, CHECK} state_t;

    state_t        state_q, state_d;
    logic [7:0]    sr_q, sr_d;
    logic [7:0]    csum_q, csum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          is_msg_q, is_msg_d;
    logic          data_q, data_d;
    logic          bit_en_q, bit_en_d;
    logic          load_key_q, load_key_d;
    logic          load_msg_q, load_msg_d;
    logic          busy_q, busy_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;

    logic [7:0]    shifted;
    logic          byte_done;
    logic [CW-1:0] len_last;

    assign shifted   = {sr_q[6:0], iSerial_in};
    assign byte_done = (cnt_q[2:0] == 3'd7);
    assign len_last  = is_msg_q ? MSG_LAST : KEY_LAST;

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        csum_d     = csum_q;
        cnt_d      = cnt_q;
        is_msg_d   = is_msg_q;
        data_d     = data_q;
        bit_en_d   = 1'b0;
        // Loads stay up between sparse payload bits and drop one cycle after the last one.
        load_key_d = load_key_q && (state_q == PAYLOAD);
        load_msg_d = load_msg_q && (state_q == PAYLOAD);
        ok_d       = 1'b0;
        err_d      = 1'b0;
        code_d     = code_q;

        if (state_q == HUNT || iEn) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (iEn) begin
            case (state_q)
                HUNT: begin
                    if (shifted == SYNC) begin
                        state_d = TYPE;
                        sr_d    = '0;
                        cnt_d   = '0;
                        csum_d  = '0;
                    end else begin
                        sr_d = shifted;
                    end
                end
                TYPE: begin
                    sr_d  = shifted;
                    cnt_d = cnt_q + 1'b1;
                    if (byte_done) begin
                        sr_d  = '0;
                        cnt_d = '0;
                        if (shifted == 8'h01) begin
                            state_d  = PAYLOAD;
                            is_msg_d = 1'b0;
                        end else if (shifted == 8'h02) begin
                            state_d  = PAYLOAD;
                            is_msg_d = 1'b1;
                        end else begin
                            state_d = HUNT;
                            err_d   = 1'b1;
                            code_d  = 2'b01;
                        end
                    end
                end
                PAYLOAD: begin
                    data_d     = iSerial_in;
                    bit_en_d   = 1'b1;
                    load_key_d = !is_msg_q;
                    load_msg_d = is_msg_q;
                    sr_d       = shifted;
                    cnt_d      = cnt_q + 1'b1;
                    if (byte_done) begin
                        csum_d = csum_q ^ shifted;
                    end
                    if (cnt_q == len_last) begin
                        state_d = CHECK;
                        sr_d    = '0;
                        cnt_d   = '0;
                    end
                end
                CHECK: begin
                    sr_d  = shifted;
                    cnt_d = cnt_q + 1'b1;
                    if (byte_done) begin
                        state_d = HUNT;
                        sr_d    = '0;
                        cnt_d   = '0;
                        if (shifted == csum_q) begin
                            ok_d   = 1'b1;
                            code_d = 2'b00;
                        end else begin
                            err_d  = 1'b1;
                            code_d = 2'b10;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end else if (state_q != HUNT && tmo_q == TMO_LAST) begin
            state_d    = HUNT;
            sr_d       = '0;
            cnt_d      = '0;
            tmo_d      = '0;
            load_key_d = 1'b0;
            load_msg_d = 1'b0;
            err_d      = 1'b1;
            code_d     = 2'b11;
        end

        busy_d = (state_d != HUNT);
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_q    <= HUNT;
            sr_q       <= '0;
            csum_q     <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            is_msg_q   <= 1'b0;
            data_q     <= 1'b0;
            bit_en_q   <= 1'b0;
            load_key_q <= 1'b0;
            load_msg_q <= 1'b0;
            busy_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            csum_q     <= csum_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            is_msg_q   <= is_msg_d;
            data_q     <= data_d;
            bit_en_q   <= bit_en_d;
            load_key_q <= load_key_d;
            load_msg_q <= load_msg_d;
            busy_q     <= busy_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    assign oData      = data_q;
    assign oBit_en    = bit_en_q;
    assign oLoad_key  = load_key_q;
    assign oLoad_msg  = load_msg_q;
    assign oBusy      = busy_q;
    assign oFrame_ok  = ok_q;
    assign oFrame_err = err_q;
    assign oErr_code  = code_q;
endmodule
